axis_rx_gearbox_64to128: RTL and testbench

//  Receive-side counterpart of the 128->64 output gearbox: packs 64-bit AXI-Stream beats into 128-bit array vectors.

---
 rtl/axis_rx_gearbox_64to128.sv | 181 ++++++++++++++++++
 tb/tb_axis_rx_gearbox_64to128.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_gearbox_64to128.sv
// axis_rx_gearbox_64to128
//   Packs 64-bit AXI-Stream beats into 128-bit words {high beat, low beat} and
//   buffers them in a small first-word-fall-through FIFO. s_axis_tready follows
//   the FIFO fill level, so upstream sees real backpressure. A frame that ends
//   on a low half is padded in [127:64] with PAD_BYTE.
//   Optional feature macro: AXIS_RX_STATS_EN adds o_frame_cnt / o_pad_cnt.
module axis_rx_gearbox_64to128 #(
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic [63:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [127:0]          m_vec_data,
    output logic                  m_vec_valid,
    input  logic                  m_vec_ready,
    output logic                  m_vec_last,
    output logic                  o_partial,
    output logic [DEPTH_LOG2:0]   o_fill
`ifdef AXIS_RX_STATS_EN
    ,
    output logic [15:0]           o_frame_cnt,
    output logic [15:0]           o_pad_cnt
`endif
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [63:0]             r_hold;
    logic [128:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wptr;
    logic [DEPTH_LOG2-1:0]   r_rptr;
    logic [DEPTH_LOG2:0]     r_fill;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_hold_load;
    logic [127:0]            w_push_data;
    logic                    w_push_last;
    logic                    w_flush;

    // Flush has the same effect as reset; rst simply wins by being OR'ed in.
    assign w_flush  = rst | i_clear;

    assign w_full   = (r_fill == FILL_MAX);
    assign w_empty  = (r_fill == '0);

    // Ready depends on the occupancy count only, never on the FSM or on tvalid.
    assign s_axis_tready = !w_full;
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_pop         = !w_empty & m_vec_ready;

    // Next-state and push decode: pair two beats, or pad a lone final low half.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = '0;
        w_push_last = 1'b0;
        w_hold_load = 1'b0;
        case (r_state)
            S_LO: begin
                if (w_accept) begin
                    if (s_axis_tlast) begin
                        w_push      = 1'b1;
                        w_push_data = {{8{PAD_BYTE}}, s_axis_tdata};
                        w_push_last = 1'b1;
                    end else begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HI;
                    end
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_push_data = {s_axis_tdata, r_hold};
                    w_push_last = s_axis_tlast;
                    w_state_nxt = S_LO;
                end
            end
            default: w_state_nxt = S_LO;
        endcase
    end

    // State register; a flush forces the next beat to be treated as a low half.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (w_flush) begin
            r_state <= S_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Low-half holding register; its content is ignored outside S_HI.
    always_ff @(posedge clk) begin
        if (w_hold_load) begin
            r_hold <= s_axis_tdata;
        end
    end

    // FIFO storage: {last, data} per entry.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the empty flag masks stale entries.
        if (w_push) begin
            r_mem[r_wptr] <= {w_push_last, w_push_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Head of FIFO is shown directly; zero while empty so outputs are clean after flush.
    assign m_vec_valid = !w_empty;
    assign m_vec_data  = w_empty ? '0   : r_mem[r_rptr][127:0];
    assign m_vec_last  = w_empty ? 1'b0 : r_mem[r_rptr][128];
    assign o_partial   = (r_state == S_HI);
    assign o_fill      = r_fill;

`ifdef AXIS_RX_STATS_EN
    logic        w_pad_push;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_pad_cnt;

    // A push from S_LO can only be a padded tail word.
    assign w_pad_push = w_push & (r_state == S_LO);

    // Frame and pad counters; 16-bit wrap is intentional.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_frame_cnt <= '0;
            r_pad_cnt   <= '0;
        end else begin
            if (w_push & w_push_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_pad_push) begin
                r_pad_cnt <= r_pad_cnt + 16'd1;
            end
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_pad_cnt   = r_pad_cnt;
`endif

endmodule

// File: tb/tb_axis_rx_gearbox_64to128.sv
// tb_axis_rx_gearbox_64to128
//   Directed self-checking bench for the 64->128 receive gearbox, PAD_BYTE=8'hEE.
module tb_axis_rx_gearbox_64to128;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_clear;
    logic [63:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [127:0] m_vec_data;
    logic         m_vec_valid;
    logic         m_vec_ready;
    logic         m_vec_last;
    logic         o_partial;
    logic [2:0]   o_fill;
`ifdef AXIS_RX_STATS_EN
    logic [15:0]  o_frame_cnt;
    logic [15:0]  o_pad_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] PAD64 = 64'hEEEE_EEEE_EEEE_EEEE;

    always #5 clk = ~clk;

    axis_rx_gearbox_64to128 #(
        .DEPTH_LOG2 (2),
        .PAD_BYTE   (8'hEE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (i_clear),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_vec_data    (m_vec_data),
        .m_vec_valid   (m_vec_valid),
        .m_vec_ready   (m_vec_ready),
        .m_vec_last    (m_vec_last),
        .o_partial     (o_partial),
        .o_fill        (o_fill)
`ifdef AXIS_RX_STATS_EN
        ,
        .o_frame_cnt   (o_frame_cnt),
        .o_pad_cnt     (o_pad_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bt(input int i);
        return 64'hB000_0000_0000_0000 | 64'(i);
    endfunction

    // Offer one beat, wait (bounded) for ready, return 1 ns after the accepting edge.
    task automatic send(input logic [63:0] d, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tready_wait", s_axis_tready, 1'b1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Wait (bounded) for a word, compare the head, then pop it.
    task automatic recv(input string tag, input logic [127:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!m_vec_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, m_vec_valid, 1'b1);
        check({tag, "_data"},  m_vec_data,  d);
        check({tag, "_last"},  m_vec_last,  l);
        m_vec_ready = 1'b1;
        @(posedge clk);
        #1;
        m_vec_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        i_clear       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_vec_ready   = 1'b0;

        // T1 reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_tready",  s_axis_tready, 1'b1);
        check("t1_valid",   m_vec_valid,   1'b0);
        check("t1_fill",    o_fill,        3'd0);
        check("t1_partial", o_partial,     1'b0);
        check("t1_data",    m_vec_data,    '0);
        @(posedge clk);
        #1;

        // T2 pair of beats
        send(64'h1111_1111_1111_1111, 1'b0);
        check("t2_partial", o_partial, 1'b1);
        send(64'h2222_2222_2222_2222, 1'b0);
        check("t2_fill", o_fill, 3'd1);
        recv("t2_w0", {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0);
        check("t2_fill_after", o_fill, 3'd0);

        // T3 odd tail padded with PAD_BYTE
        send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        send(64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
        send(64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
        check("t3_partial", o_partial, 1'b0);
        recv("t3_w0", {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0);
        recv("t3_w1", {PAD64, 64'hCCCC_CCCC_CCCC_CCCC}, 1'b1);

        // T4 backpressure: fill to 4 words, then drain while the last 2 beats enter
        for (int i = 0; i < 8; i++) begin
            send(bt(i), 1'b0);
        end
        @(negedge clk);
        check("t4_tready_full", s_axis_tready, 1'b0);
        check("t4_fill_full",   o_fill,        3'd4);
        check("t4_partial",     o_partial,     1'b0);
        @(posedge clk);
        #1;
        fork
            begin
                send(bt(8), 1'b0);
                send(bt(9), 1'b0);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    recv($sformatf("t4_w%0d", k), {bt(2 * k + 1), bt(2 * k)}, 1'b0);
                end
            end
        join
        recv("t4_w4", {bt(9), bt(8)}, 1'b0);
        check("t4_fill_end", o_fill, 3'd0);

        // T5 flush mid-word discards the held low half
        send(64'hAAAA_0000_AAAA_0000, 1'b0);
        check("t5_partial_set", o_partial, 1'b1);
        pulse_clear();
        check("t5_partial_clr", o_partial, 1'b0);
        check("t5_fill_clr",    o_fill,    3'd0);
        send(64'hBBBB_0000_BBBB_0000, 1'b0);
        send(64'hCCCC_0000_CCCC_0000, 1'b0);
        recv("t5_w0", {64'hCCCC_0000_CCCC_0000, 64'hBBBB_0000_BBBB_0000}, 1'b0);
        check("t5_fill_end", o_fill, 3'd0);

        // T5b flush empties a non-empty FIFO
        send(64'h1234_5678_9ABC_DEF0, 1'b0);
        send(64'h0FED_CBA9_8765_4321, 1'b1);
        check("t5b_valid_pre", m_vec_valid, 1'b1);
        pulse_clear();
        check("t5b_valid_clr", m_vec_valid, 1'b0);
        check("t5b_fill_clr",  o_fill,      3'd0);
        check("t5b_data_clr",  m_vec_data,  '0);

        // T7 tlast on the high half: unpadded word with last=1
        send(64'hDDDD_DDDD_DDDD_DDDD, 1'b0);
        send(64'h5555_5555_5555_5555, 1'b1);
        recv("t7_w0", {64'h5555_5555_5555_5555, 64'hDDDD_DDDD_DDDD_DDDD}, 1'b1);

`ifdef AXIS_RX_STATS_EN
        // T6 statistics: back-to-back frames of 3 and 4 beats
        pulse_clear();
        check("t6_frame_clr", o_frame_cnt, 16'd0);
        check("t6_pad_clr",   o_pad_cnt,   16'd0);
        send(bt(20), 1'b0);
        send(bt(21), 1'b0);
        send(bt(22), 1'b1);
        send(bt(30), 1'b0);
        send(bt(31), 1'b0);
        send(bt(32), 1'b0);
        send(bt(33), 1'b1);
        check("t6_frame_cnt", o_frame_cnt, 16'd2);
        check("t6_pad_cnt",   o_pad_cnt,   16'd1);
        recv("t6_w0", {bt(21), bt(20)}, 1'b0);
        recv("t6_w1", {PAD64, bt(22)},  1'b1);
        recv("t6_w2", {bt(31), bt(30)}, 1'b0);
        recv("t6_w3", {bt(33), bt(32)}, 1'b1);
`endif

        @(negedge clk);
        check("end_fill", o_fill, 3'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
